// File: rtl/xbar_req_router_if.sv
// Request-side bundle for xbar_req_router.
//   master modport : the environment around the router (bus master, slaves, tag sequencer);
//                    drives m_req_i/m_we_i/m_addr_bi/m_wdata_bi, s_ack_i, tag_fifo_full.
//   slave modport  : the router itself; drives m_ack_o/m_err_o, s_req_o/s_we_o/s_addr_bo/
//                    s_wdata_bo, tag_fifo_wrreq/tag_fifo_wdata.
// Signal names keep the router's port names so the router's ports are recognisable.
interface xbar_req_router_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 2
);
  // master side
  logic                  m_req_i;
  logic                  m_we_i;
  logic [ADDR_WIDTH-1:0] m_addr_bi;
  logic [DATA_WIDTH-1:0] m_wdata_bi;
  logic                  m_ack_o;
  logic                  m_err_o;
  // slave side
  logic [3:0]            s_req_o;
  logic [3:0]            s_ack_i;
  logic                  s_we_o;
  logic [ADDR_WIDTH-1:0] s_addr_bo;
  logic [DATA_WIDTH-1:0] s_wdata_bo;
  // reorder-sequencer tag FIFO
  logic                  tag_fifo_full;
  logic                  tag_fifo_wrreq;
  logic [TAG_WIDTH-1:0]  tag_fifo_wdata;

  modport master (
    output m_req_i, m_we_i, m_addr_bi, m_wdata_bi, s_ack_i, tag_fifo_full,
    input  m_ack_o, m_err_o, s_req_o, s_we_o, s_addr_bo, s_wdata_bo,
           tag_fifo_wrreq, tag_fifo_wdata
  );

  modport slave (
    input  m_req_i, m_we_i, m_addr_bi, m_wdata_bi, s_ack_i, tag_fifo_full,
    output m_ack_o, m_err_o, s_req_o, s_we_o, s_addr_bo, s_wdata_bo,
           tag_fifo_wrreq, tag_fifo_wdata
  );
endinterface

// File: rtl/xbar_req_router.sv
// Single-outstanding request router from one master to four slaves.
// A request is captured in IDLE (reads only when the sequencer tag FIFO has room), its
// address/data/direction are held on the shared slave bus, and a one-hot request goes to the
// slave chosen by addr[SEL_LSB+1:SEL_LSB] until that slave acks. Completed reads push the
// slave index into the reorder-sequencer tag FIFO so responses can be returned in order.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : xbar_req_router_if.slave -- master handshake, slave bus, tag FIFO push
//
// Optional feature: define ROUTER_TIMEOUT_EN to abort a request that is not acked within
// TIMEOUT_CYCLES WAIT cycles (m_ack_o with m_err_o). Without it m_err_o is tied 0.
module xbar_req_router #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TAG_WIDTH      = 2,
  parameter int unsigned SEL_LSB        = 30,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk_i,
  input logic            rst_i,
  xbar_req_router_if.slave bus
);

  // Elaboration-time configuration checks.
  if (TAG_WIDTH != 2) begin : gen_bad_tag_width
    $error("xbar_req_router: TAG_WIDTH must be 2");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gen_bad_timeout
    $error("xbar_req_router: TIMEOUT_CYCLES must be in 1..255");
  end
  if (SEL_LSB + 2 > ADDR_WIDTH) begin : gen_bad_sel
    $error("xbar_req_router: select field outside address");
  end

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            sel_q, sel_d;

  logic                  capture;
  logic                  ack_sel;
  logic                  timeout;
  logic                  m_ack;
  logic                  m_err;
  logic                  tag_push;
  logic [3:0]            s_req;

  // Only the selected slave's ack counts; the others are don't-care.
  assign ack_sel = bus.s_ack_i[sel_q];

`ifdef ROUTER_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  // cnt_q counts completed ack-less WAIT cycles, so the Nth WAIT cycle sees N-1.
  assign timeout = (state_q == StWait) && (cnt_q == TimeoutLast);

  always_comb begin
    cnt_d = cnt_q;
    if (capture) begin
      cnt_d = 8'd0;
    end else if (state_q == StWait && !ack_sel) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and decoded outputs.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    capture  = 1'b0;
    m_ack    = 1'b0;
    m_err    = 1'b0;
    tag_push = 1'b0;
    s_req    = 4'b0000;

    unique case (state_q)
      StIdle: begin
        // Full check happens only here: with one request outstanding and a pop-only
        // sequencer, a slot reserved now is still free at the later push.
        if (bus.m_req_i && (bus.m_we_i || !bus.tag_fifo_full)) begin
          capture = 1'b1;
          we_d    = bus.m_we_i;
          addr_d  = bus.m_addr_bi;
          wdata_d = bus.m_wdata_bi;
          sel_d   = bus.m_addr_bi[SEL_LSB +: 2];
          state_d = StWait;
        end
      end
      StWait: begin
        unique case (sel_q)
          2'd0: s_req = 4'b0001;
          2'd1: s_req = 4'b0010;
          2'd2: s_req = 4'b0100;
          2'd3: s_req = 4'b1000;
          default: s_req = 4'b0000;
        endcase
        if (ack_sel) begin
          // An ack in the timeout cycle wins: normal completion.
          m_ack    = 1'b1;
          tag_push = !we_q;
          state_d  = StIdle;
        end else if (timeout) begin
          m_ack   = 1'b1;
          m_err   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.m_ack_o        = m_ack;
  assign bus.m_err_o        = m_err;
  assign bus.s_req_o        = s_req;
  assign bus.s_we_o         = we_q;
  assign bus.s_addr_bo      = addr_q;
  assign bus.s_wdata_bo     = wdata_q;
  assign bus.tag_fifo_wrreq = tag_push;
  // Tag is the registered select; it stays stable whether or not a push is happening.
  assign bus.tag_fifo_wdata = TAG_WIDTH'(sel_q);

  // Structural invariants.
  a_req_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(s_req));
  a_push_read  : assert property (@(posedge clk_i) disable iff (rst_i)
                                  tag_push |-> (m_ack && !m_err && !we_q));
  a_err_ack    : assert property (@(posedge clk_i) disable iff (rst_i) m_err |-> m_ack);

endmodule

// File: tb/tb_xbar_req_router.sv
module tb_xbar_req_router;

`ifdef ROUTER_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Scoreboard: expected m_err_o per m_ack_o event, expected tag per tag push.
  bit          exp_err_q[$];
  logic [1:0]  exp_tag_q[$];

  xbar_req_router_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(2)) bus ();

  xbar_req_router #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TAG_WIDTH     (2),
    .SEL_LSB       (30),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops scoreboard entries whenever the DUT completes or pushes a tag.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_ack_o === 1'b1) begin
        total++;
        if (exp_err_q.size() == 0) begin
          bad++;
          $display("FAIL ack_unexpected: m_ack_o=1 with no request expected to finish");
        end else begin
          bit e;
          e = exp_err_q.pop_front();
          if (bus.m_err_o !== e) begin
            bad++;
            $display("FAIL ack_err: m_err_o=%b expected %b", bus.m_err_o, e);
          end
        end
      end else if (bus.m_err_o !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL err_without_ack: m_err_o=%b expected 0", bus.m_err_o);
      end
      if (bus.tag_fifo_wrreq === 1'b1) begin
        total++;
        if (exp_tag_q.size() == 0) begin
          bad++;
          $display("FAIL tag_unexpected: push of tag %0d not expected", bus.tag_fifo_wdata);
        end else begin
          logic [1:0] t;
          t = exp_tag_q.pop_front();
          if (bus.tag_fifo_wdata !== t) begin
            bad++;
            $display("FAIL tag_value: tag=%0d expected %0d", bus.tag_fifo_wdata, t);
          end
        end
      end
    end
  end

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.m_req_i    = 1'b1;
    bus.m_we_i     = we;
    bus.m_addr_bi  = addr;
    bus.m_wdata_bi = wd;
  endtask

  task automatic idle_master();
    bus.m_req_i    = 1'b0;
    bus.m_we_i     = 1'b0;
    bus.m_addr_bi  = '0;
    bus.m_wdata_bi = '0;
    bus.s_ack_i    = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b0000 || bus.m_ack_o !== 1'b0 || bus.tag_fifo_wrreq !== 1'b0 ||
        bus.m_err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: s_req=%b ack=%b err=%b push=%b expected all 0",
               bus.s_req_o, bus.m_ack_o, bus.m_err_o, bus.tag_fifo_wrreq);
    end
    total++;
    if (bus.s_we_o !== 1'b0 || bus.s_addr_bo !== 32'h0 || bus.s_wdata_bo !== 32'h0 ||
        bus.tag_fifo_wdata !== 2'd0) begin
      bad++;
      $display("FAIL reset_bus: we=%b addr=%h wdata=%h tag=%0d expected 0",
               bus.s_we_o, bus.s_addr_bo, bus.s_wdata_bo, bus.tag_fifo_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Read from slave 2, ack arrives on the third s_req cycle.
  task automatic test_read_latency();
    @(posedge clk); #1;
    drive_req(1'b0, 32'h8000_0010, 32'h0);
    exp_err_q.push_back(1'b0);
    exp_tag_q.push_back(2'd2);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) bus.s_ack_i = 4'b0100;
      @(negedge clk);
      total++;
      if (bus.s_req_o !== 4'b0100) begin
        bad++;
        $display("FAIL read_sreq c%0d: s_req=%b expected 0100", k, bus.s_req_o);
      end
      total++;
      if (bus.m_ack_o !== (k == 2) || bus.tag_fifo_wrreq !== (k == 2)) begin
        bad++;
        $display("FAIL read_ack c%0d: ack=%b push=%b expected %0d", k, bus.m_ack_o,
                 bus.tag_fifo_wrreq, (k == 2));
      end
      total++;
      if (bus.tag_fifo_wdata !== 2'd2 || bus.s_addr_bo !== 32'h8000_0010 ||
          bus.s_we_o !== 1'b0) begin
        bad++;
        $display("FAIL read_bus c%0d: tag=%0d addr=%h we=%b expected 2/80000010/0", k,
                 bus.tag_fifo_wdata, bus.s_addr_bo, bus.s_we_o);
      end
    end
    @(posedge clk); #1;
    idle_master();
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b0000) begin
      bad++;
      $display("FAIL read_release: s_req=%b expected 0000", bus.s_req_o);
    end
  endtask

  // Write to slave 1 with a zero-latency ack.
  task automatic test_write_zero_latency();
    @(posedge clk); #1;
    drive_req(1'b1, 32'h4000_0000, 32'hDEAD_BEEF);
    bus.s_ack_i = 4'b0010;
    exp_err_q.push_back(1'b0);
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b0000 || bus.m_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL write_pre: s_req=%b ack=%b expected 0000/0", bus.s_req_o, bus.m_ack_o);
    end
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b0010 || bus.m_ack_o !== 1'b1 || bus.tag_fifo_wrreq !== 1'b0) begin
      bad++;
      $display("FAIL write_ack: s_req=%b ack=%b push=%b expected 0010/1/0",
               bus.s_req_o, bus.m_ack_o, bus.tag_fifo_wrreq);
    end
    total++;
    if (bus.s_wdata_bo !== 32'hDEAD_BEEF || bus.s_we_o !== 1'b1) begin
      bad++;
      $display("FAIL write_data: wdata=%h we=%b expected deadbeef/1",
               bus.s_wdata_bo, bus.s_we_o);
    end
    @(posedge clk); #1;
    idle_master();
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b0000) begin
      bad++;
      $display("FAIL write_release: s_req=%b expected 0000", bus.s_req_o);
    end
  endtask

  // Read blocked while the tag FIFO is full; a write is not.
  task automatic test_fifo_full();
    @(posedge clk); #1;
    bus.tag_fifo_full = 1'b1;
    drive_req(1'b0, 32'hC000_0000, 32'h0);
    bus.s_ack_i = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (bus.s_req_o !== 4'b0000 || bus.m_ack_o !== 1'b0) begin
        bad++;
        $display("FAIL full_block c%0d: s_req=%b ack=%b expected 0000/0", k,
                 bus.s_req_o, bus.m_ack_o);
      end
      @(posedge clk);
    end
    #1;
    bus.tag_fifo_full = 1'b0;
    exp_err_q.push_back(1'b0);
    exp_tag_q.push_back(2'd3);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b1000 || bus.m_ack_o !== 1'b1) begin
      bad++;
      $display("FAIL full_release: s_req=%b ack=%b expected 1000/1", bus.s_req_o, bus.m_ack_o);
    end
    @(posedge clk); #1;
    idle_master();
    @(posedge clk); #1;
    bus.tag_fifo_full = 1'b1;
    drive_req(1'b1, 32'h0000_0004, 32'h1234_5678);
    bus.s_ack_i = 4'b0001;
    exp_err_q.push_back(1'b0);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b0001 || bus.m_ack_o !== 1'b1 || bus.tag_fifo_wrreq !== 1'b0) begin
      bad++;
      $display("FAIL full_write: s_req=%b ack=%b push=%b expected 0001/1/0",
               bus.s_req_o, bus.m_ack_o, bus.tag_fifo_wrreq);
    end
    @(posedge clk); #1;
    idle_master();
    bus.tag_fifo_full = 1'b0;
  endtask

  // Acks from non-selected slaves are ignored.
  task automatic test_ignore_other_ack();
    @(posedge clk); #1;
    drive_req(1'b0, 32'h0000_0100, 32'h0);
    exp_err_q.push_back(1'b0);
    exp_tag_q.push_back(2'd0);
    @(posedge clk); #1;
    bus.s_ack_i = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (bus.s_req_o !== 4'b0001 || bus.m_ack_o !== 1'b0 || bus.tag_fifo_wrreq !== 1'b0) begin
        bad++;
        $display("FAIL ignore c%0d: s_req=%b ack=%b push=%b expected 0001/0/0", k,
                 bus.s_req_o, bus.m_ack_o, bus.tag_fifo_wrreq);
      end
      @(posedge clk); #1;
    end
    bus.s_ack_i = 4'b1001;
    @(negedge clk);
    total++;
    if (bus.m_ack_o !== 1'b1 || bus.tag_fifo_wrreq !== 1'b1) begin
      bad++;
      $display("FAIL ignore_done: ack=%b push=%b expected 1/1", bus.m_ack_o, bus.tag_fifo_wrreq);
    end
    @(posedge clk); #1;
    idle_master();
  endtask

  // Request held continuously: one idle cycle between s_req bursts.
  task automatic test_back_to_back();
    @(posedge clk); #1;
    drive_req(1'b0, 32'h4000_0020, 32'h0);
    bus.s_ack_i = 4'b0010;
    exp_err_q.push_back(1'b0);
    exp_tag_q.push_back(2'd1);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b0010 || bus.m_ack_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: s_req=%b ack=%b expected 0010/1", bus.s_req_o, bus.m_ack_o);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 32'h8000_0030, 32'h0);
    bus.s_ack_i = 4'b0100;
    exp_err_q.push_back(1'b0);
    exp_tag_q.push_back(2'd2);
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b0000) begin
      bad++;
      $display("FAIL b2b_gap: s_req=%b expected 0000", bus.s_req_o);
    end
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b0100 || bus.m_ack_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: s_req=%b ack=%b expected 0100/1", bus.s_req_o, bus.m_ack_o);
    end
    @(posedge clk); #1;
    idle_master();
  endtask

  // Reset while waiting abandons the request; the next read works normally.
  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    drive_req(1'b0, 32'hC000_0040, 32'h0);
    @(posedge clk); #1;
    idle_master();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b1000) begin
      bad++;
      $display("FAIL rstwait_pre: s_req=%b expected 1000", bus.s_req_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b0000 || bus.tag_fifo_wrreq !== 1'b0 || bus.m_ack_o !== 1'b0 ||
        bus.s_addr_bo !== 32'h0) begin
      bad++;
      $display("FAIL rstwait_post: s_req=%b push=%b ack=%b addr=%h expected 0",
               bus.s_req_o, bus.tag_fifo_wrreq, bus.m_ack_o, bus.s_addr_bo);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 32'h8000_0000, 32'h0);
    bus.s_ack_i = 4'b0100;
    exp_err_q.push_back(1'b0);
    exp_tag_q.push_back(2'd2);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.s_req_o !== 4'b0100 || bus.tag_fifo_wrreq !== 1'b1) begin
      bad++;
      $display("FAIL rstwait_next: s_req=%b push=%b expected 0100/1",
               bus.s_req_o, bus.tag_fifo_wrreq);
    end
    @(posedge clk); #1;
    idle_master();
  endtask

`ifdef ROUTER_TIMEOUT_EN
  // No ack: abort on the 4th WAIT cycle; then an ack in that same cycle wins.
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk); #1;
      drive_req(1'b0, 32'h4000_0000, 32'h0);
      exp_err_q.push_back(pass == 0);
      if (pass == 1) exp_tag_q.push_back(2'd1);
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk); #1;
        if (pass == 1 && k == 4) bus.s_ack_i = 4'b0010;
        @(negedge clk);
        total++;
        if (bus.m_ack_o !== (k == 4) || bus.m_err_o !== (pass == 0 && k == 4) ||
            bus.tag_fifo_wrreq !== (pass == 1 && k == 4)) begin
          bad++;
          $display("FAIL timeout p%0d c%0d: ack=%b err=%b push=%b", pass, k,
                   bus.m_ack_o, bus.m_err_o, bus.tag_fifo_wrreq);
        end
      end
      @(posedge clk); #1;
      idle_master();
      @(negedge clk);
      total++;
      if (bus.s_req_o !== 4'b0000) begin
        bad++;
        $display("FAIL timeout_release p%0d: s_req=%b expected 0000", pass, bus.s_req_o);
      end
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.tag_fifo_full = 1'b0;
    idle_master();
    test_reset();
    test_read_latency();
    test_write_zero_latency();
    test_fifo_full();
    test_ignore_other_ack();
    test_back_to_back();
    test_reset_in_wait();
`ifdef ROUTER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(posedge clk);
    total++;
    if (exp_err_q.size() != 0 || exp_tag_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d acks and %0d tags expected but never seen",
               exp_err_q.size(), exp_tag_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

endmodule
